// File: rtl/nibble_alu_pkg.sv
// Shared constants for the nibble-serial ALU:
// opcodes, FSM state codes and 74181-style ALU controls.
package nibble_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] SEL_ADD  = 4'b1001;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_AND  = 4'b1011;
    localparam logic [3:0] SEL_OR   = 4'b1110;
    localparam logic [3:0] SEL_XOR  = 4'b0110;
    localparam logic [3:0] SEL_PASS = 4'b1111;

    // Returns {M, Sel}; reserved opcodes fall through to PASS_A.
    function automatic logic [4:0] alu_ctrl(input logic [2:0] op);
        logic [4:0] c;
        case (op)
            OP_ADD:  c = {1'b0, SEL_ADD};
            OP_SUB:  c = {1'b0, SEL_SUB};
            OP_AND:  c = {1'b1, SEL_AND};
            OP_OR:   c = {1'b1, SEL_OR};
            OP_XOR:  c = {1'b1, SEL_XOR};
            default: c = {1'b1, SEL_PASS};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/nibble_alu_seq_alu.sv
// 4-bit 74181-style ALU slice with active-low carry in/out,
// active-high data, and a per-nibble equality flag.
module alu_4bit
    import nibble_alu_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [3:0] sel_i,
    input  logic       m_i,
    input  logic       cn_i,
    output logic [3:0] f_o,
    output logic       cn4_o,
    output logic       eq_o
);

    logic [4:0] sum;

    always_comb begin
        sum   = '0;
        f_o   = a_i;
        cn4_o = 1'b1;
        if (!m_i) begin
            case (sel_i)
                SEL_ADD: sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0, ~cn_i};
                SEL_SUB: sum = {1'b0, a_i} + {1'b0, ~b_i} + {4'b0, ~cn_i};
                default: sum = {1'b1, a_i};
            endcase
            f_o   = sum[3:0];
            cn4_o = ~sum[4];
        end else begin
            case (sel_i)
                SEL_AND: f_o = a_i & b_i;
                SEL_OR:  f_o = a_i | b_i;
                SEL_XOR: f_o = a_i ^ b_i;
                default: f_o = a_i;
            endcase
        end
    end

    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/nibble_alu_seq.sv
// Nibble-serial 16-bit ALU: one alu_4bit slice is reused
// LSB-first across NIBBLES cycles, with a registered ripple carry.
module nibble_alu_seq
    import nibble_alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry_out,
    output logic                 zero,
    output logic                 eq
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic [1:0]    st_q, st_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic          cn_q, cn_d;
    logic          eq_q, eq_d;
    logic          cout_q, cout_d;
    logic          zero_q, zero_d;

    logic [3:0] a_nib, b_nib, f;
    logic [4:0] ctrl;
    logic       cin, cn4, eq_nib, arith, last;

    assign ctrl  = alu_ctrl(op_q);
    assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign last  = (idx_q == IW'(NIBBLES - 1));
    // Carry is active-low: 1 means "no carry in" for ADD, 0 injects the +1 for SUB.
    assign cin   = (idx_q == '0) ? (op_q != OP_SUB) : cn_q;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    alu_4bit u_alu (
        .a_i   (a_nib),
        .b_i   (b_nib),
        .sel_i (ctrl[3:0]),
        .m_i   (ctrl[4]),
        .cn_i  (cin),
        .f_o   (f),
        .cn4_o (cn4),
        .eq_o  (eq_nib)
    );

    always_comb begin
        st_d   = st_q;
        idx_d  = idx_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        cn_d   = cn_q;
        eq_d   = eq_q;
        cout_d = cout_q;
        zero_d = zero_q;
        case (st_q)
            S_IDLE, S_DONE: begin
                st_d = S_IDLE;
                if (start) begin
                    st_d   = S_RUN;
                    idx_d  = '0;
                    op_d   = op;
                    a_d    = a;
                    b_d    = b;
                    res_d  = '0;
                    cn_d   = 1'b1;
                    eq_d   = 1'b1;
                    cout_d = 1'b0;
                    zero_d = 1'b0;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) res_d[4*i +: 4] = f;
                end
                cn_d = cn4;
                eq_d = eq_q & eq_nib;
                if (last) begin
                    st_d   = S_DONE;
                    cout_d = arith & ~cn4;
                    zero_d = (res_d == '0);
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= S_IDLE;
            idx_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            cn_q   <= 1'b0;
            eq_q   <= 1'b0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            cn_q   <= cn_d;
            eq_q   <= eq_d;
            cout_q <= cout_d;
            zero_q <= zero_d;
        end
    end

    assign busy      = (st_q == S_RUN);
    assign done      = (st_q == S_DONE);
    assign result    = res_q;
    assign carry_out = cout_q;
    assign zero      = zero_q;
    assign eq        = eq_q;

endmodule

// File: tb/tb_nibble_alu_seq.sv
// Directed, table-driven bench for nibble_alu_seq.
// Expected values are hand-computed constants.
module tb_nibble_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        busy, done, carry_out, zero, eq;
    logic [15:0] result;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        cout;
        logic        zero;
        logic        eq;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    nibble_alu_seq #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .eq        (eq)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one start at the next edge; returns cycles until done is seen.
    task automatic run_op(input logic [2:0] o, input logic [15:0] x,
                          input logic [15:0] y, output int lat);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t v);
        chk({tag, " result"}, 32'(result), 32'(v.res));
        chk({tag, " carry_out"}, 32'(carry_out), 32'(v.cout));
        chk({tag, " zero"}, 32'(zero), 32'(v.zero));
        chk({tag, " eq"}, 32'(eq), 32'(v.eq));
    endtask

    initial begin
        int   lat;
        vec_t v;
        vecs[0]  = '{3'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'd4, 16'hA5A5, 16'h0FF0, 16'hAA55, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd3, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd5, 16'hBEEF, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{3'd1, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'd7, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{3'd0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset result", 32'(result), 0);
        chk("reset carry_out", 32'(carry_out), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", 32'(busy), 0);

        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            run_op(v.op, v.a, v.b, lat);
            chk($sformatf("v%0d latency", i), 32'(lat), 5);
            chk($sformatf("v%0d busy@done", i), 32'(busy), 0);
            chk_outs($sformatf("v%0d", i), v);
            @(negedge clk);
            chk($sformatf("v%0d done pulse", i), 32'(done), 0);
            chk($sformatf("v%0d held", i), 32'(result), 32'(v.res));
        end

        // Back-to-back: start held high in the DONE cycle.
        run_op(3'd4, 16'hA5A5, 16'h0FF0, lat);
        chk("b2b first result", 32'(result), 32'h0000AA55);
        start = 1'b1;
        op    = 3'd0;
        a     = 16'h1111;
        b     = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        chk("b2b no idle busy", 32'(busy), 1);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b latency", 32'(lat), 5);
        chk("b2b second result", 32'(result), 32'h00003333);

        // Start during RUN with different operands is ignored.
        @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        a     = 16'h0102;
        b     = 16'h0304;
        @(negedge clk);
        op    = 3'd3;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("run-start latency", 32'(lat), 5);
        chk("run-start result", 32'(result), 32'h00000406);

        // Asynchronous reset while nibble 2 is being processed.
        @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        a     = 16'h5555;
        b     = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid busy", 32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst result", 32'(result), 0);
        chk("rst carry_out", 32'(carry_out), 0);
        chk("rst zero", 32'(zero), 0);
        chk("rst eq", 32'(eq), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst idle", 32'(busy), 0);
        run_op(3'd0, 16'h0003, 16'h0004, lat);
        chk("post-rst latency", 32'(lat), 5);
        chk("post-rst result", 32'(result), 32'h00000007);
        chk("post-rst carry_out", 32'(carry_out), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
